// File: rtl/rps_game_ctrl.sv
// Rock-paper-scissors round controller: synchronised button events, a free-running
// rotor for the computer hand, a timed reveal phase and saturating win/lose tallies.
module rps_game_ctrl #(
  parameter int unsigned REVEAL_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_rock,
  input  logic       btn_paper,
  input  logic       btn_scissors,
  output logic [1:0] state,
  output logic [1:0] player_hand,
  output logic [1:0] com_hand,
  output logic [1:0] result,
  output logic [3:0] win_cnt,
  output logic [3:0] lose_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for the first start after reset
  // S_PLAY   | waiting for a hand button
  // S_REVEAL | hands shown, timer counting down to the verdict
  // S_RESULT | verdict shown, waiting for start of next round
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_REVEAL = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [25:0] TIMER_LOAD = 26'(REVEAL_CYCLES - 1);

  logic [3:0]  w_btn;
  logic [3:0]  r_sync1, r_sync2, r_prev;
  logic [3:0]  w_evt;
  logic [1:0]  r_rotor;
  state_t      r_state, w_state_nxt;
  logic [1:0]  r_player, w_player_nxt;
  logic [1:0]  r_com, w_com_nxt;
  logic [1:0]  r_result, w_result_nxt;
  logic [3:0]  r_win, w_win_nxt;
  logic [3:0]  r_lose, w_lose_nxt;
  logic [25:0] r_timer, w_timer_nxt;
  logic        w_player_wins, w_player_loses;

  // bit 0 start, 1 rock, 2 paper, 3 scissors
  assign w_btn = {btn_scissors, btn_paper, btn_rock, btn_start};
  assign w_evt = r_sync2 & ~r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_rotor <= 2'd1;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rotor <= (r_rotor == 2'd3) ? 2'd1 : r_rotor + 2'd1;
    end
  end

  assign w_player_wins  = (r_player == 2'd1 && r_com == 2'd3) ||
                          (r_player == 2'd2 && r_com == 2'd1) ||
                          (r_player == 2'd3 && r_com == 2'd2);
  assign w_player_loses = (r_player != r_com) && !w_player_wins;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_player <= 2'd0;
      r_com    <= 2'd0;
      r_result <= 2'd0;
      r_win    <= 4'd0;
      r_lose   <= 4'd0;
      r_timer  <= 26'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_player <= w_player_nxt;
      r_com    <= w_com_nxt;
      r_result <= w_result_nxt;
      r_win    <= w_win_nxt;
      r_lose   <= w_lose_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_player_nxt = r_player;
    w_com_nxt    = r_com;
    w_result_nxt = r_result;
    w_win_nxt    = r_win;
    w_lose_nxt   = r_lose;
    w_timer_nxt  = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_evt[0]) begin
          w_state_nxt  = S_PLAY;
          w_player_nxt = 2'd0;
          w_com_nxt    = 2'd0;
          w_result_nxt = 2'd0;
        end
      end
      S_PLAY: begin
        if (|w_evt[3:1]) begin
          w_state_nxt  = S_REVEAL;
          w_player_nxt = w_evt[1] ? 2'd1 : (w_evt[2] ? 2'd2 : 2'd3);
          w_com_nxt    = r_rotor;
          w_timer_nxt  = TIMER_LOAD;
        end
      end
      S_REVEAL: begin
        if (r_timer == 26'd0) begin
          w_state_nxt = S_RESULT;
          if (w_player_wins) begin
            w_result_nxt = 2'd1;
            if (r_win != 4'd9) w_win_nxt = r_win + 4'd1;
          end else if (w_player_loses) begin
            w_result_nxt = 2'd2;
            if (r_lose != 4'd9) w_lose_nxt = r_lose + 4'd1;
          end else begin
            w_result_nxt = 2'd3;
          end
        end else begin
          w_timer_nxt = r_timer - 26'd1;
        end
      end
      S_RESULT: begin
        if (w_evt[0]) begin
          w_state_nxt  = S_PLAY;
          w_player_nxt = 2'd0;
          w_com_nxt    = 2'd0;
          w_result_nxt = 2'd0;
          // a full 9/9 scoreboard starts a fresh match
          if (r_win == 4'd9 && r_lose == 4'd9) begin
            w_win_nxt  = 4'd0;
            w_lose_nxt = 4'd0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state       = r_state;
  assign player_hand = r_player;
  assign com_hand    = r_com;
  assign result      = r_result;
  assign win_cnt     = r_win;
  assign lose_cnt    = r_lose;

endmodule

// File: tb/tb_rps_game_ctrl.sv
// Scoreboard bench for rps_game_ctrl: a round-level game model predicts each output
// change and its clock edge; a monitor pops and compares on every observed change.
module tb_rps_game_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0, btn_rock = 1'b0, btn_paper = 1'b0, btn_scissors = 1'b0;
  logic [1:0] state, player_hand, com_hand, result;
  logic [3:0] win_cnt, lose_cnt;

  rps_game_ctrl #(.REVEAL_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_rock(btn_rock), .btn_paper(btn_paper), .btn_scissors(btn_scissors),
    .state(state), .player_hand(player_hand), .com_hand(com_hand), .result(result),
    .win_cnt(win_cnt), .lose_cnt(lose_cnt)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [15:0] v;
    int          e;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rel      = 0;
  int m_phase  = 0;   // 0 idle, 1 play, 3 result (reveal covered by m_res_edge)
  int m_win    = 0;
  int m_lose   = 0;
  int m_res_edge = 0;

  function automatic logic [15:0] snap_now();
    return {state, player_hand, com_hand, result, win_cnt, lose_cnt};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at edge %0d", nm, got, exp, edge_cnt);
    end
  endtask

  task automatic push(input int st, input int h, input int c, input int r,
                      input int w, input int l, input int e);
    exp_t x;
    x.v = {2'(st), 2'(h), 2'(c), 2'(r), 4'(w), 4'(l)};
    x.e = e;
    q.push_back(x);
  endtask

  // Game rules applied to the button events that take effect on edge e.
  task automatic model_at(input int e, input logic [3:0] mask);
    int h, c, d, r;
    if (m_phase == 3 && e <= m_res_edge) return;
    case (m_phase)
      0: if (mask[0]) begin
        m_phase = 1;
        push(1, 0, 0, 0, m_win, m_lose, e);
      end
      1: if (mask[3:1] != 3'b000) begin
        h = mask[1] ? 1 : (mask[2] ? 2 : 3);
        c = ((e - 1 - rel) % 3) + 1;
        push(2, h, c, 0, m_win, m_lose, e);
        d = (h - c + 3) % 3;
        r = (d == 0) ? 3 : ((d == 1) ? 1 : 2);
        if (r == 1 && m_win < 9) m_win++;
        if (r == 2 && m_lose < 9) m_lose++;
        push(3, h, c, r, m_win, m_lose, e + N);
        m_phase = 3;
        m_res_edge = e + N;
      end
      default: if (mask[0]) begin
        if (m_win == 9 && m_lose == 9) begin
          m_win = 0;
          m_lose = 0;
        end
        m_phase = 1;
        push(1, 0, 0, 0, m_win, m_lose, e);
      end
    endcase
  endtask

  task automatic drive(input logic [3:0] mask);
    {btn_scissors, btn_paper, btn_rock, btn_start} = mask;
  endtask

  // Called at a falling edge; the press is first sampled on the next rising edge.
  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    model_at(edge_cnt + 3, mask);
    drive(mask);
    repeat (hold) @(negedge clk);
    drive(4'b0000);
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_for_com(input logic [3:0] mask, input int want, input int gap);
    while ((((edge_cnt + 2 - rel) % 3) + 1) != want) @(negedge clk);
    press(mask, 1, gap);
  endtask

  // Monitor: every change of the registered outputs must match the next expectation.
  initial begin
    logic [15:0] prev, cur;
    exp_t x;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = snap_now();
      if (cur !== prev) begin
        if (q.size() == 0) begin
          check("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          x = q.pop_front();
          check("outputs", 32'(cur), 32'(x.v));
          if (x.e >= 0) check("edge_time", edge_cnt, x.e);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, e;
    logic [3:0] mask;
    #1 rst = 1'b0;
    #1 check("reset_outputs", 32'(snap_now()), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rel = edge_cnt;

    press(4'b0001, 1, 3);                    // start -> PLAY
    press_for_com(4'b0010, 3, N + 3);        // rock vs scissors: win
    press(4'b0001, 1, 2);
    press(4'b1010, 1, N + 3);                // rock+scissors together
    press(4'b0001, 1, 2);
    press(4'b0010, 100, 3);                  // rock held long: one event only

    for (int i = 0; i < 11; i++) begin       // paper vs scissors: losses
      press(4'b0001, 1, 2);
      press_for_com(4'b0100, 3, N + 3);
    end
    press(4'b0001, 1, 2);
    press_for_com(4'b0100, 2, N + 3);        // draw
    while (m_win < 9) begin
      press(4'b0001, 1, 2);
      press_for_com(4'b0010, 3, N + 3);
    end
    press(4'b0001, 1, 3);                    // 9/9 start clears tallies

    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: mask = 4'b0001;
        3:       mask = 4'b0010;
        4:       mask = 4'b0100;
        5:       mask = 4'b1000;
        6:       mask = 4'b0110;
        7:       mask = 4'b1100;
        8:       mask = 4'b0011;
        default: mask = 4'b1111;
      endcase
      press(mask, $urandom_range(1, 4), $urandom_range(1, 6));
    end

    // Reset in the middle of REVEAL.
    while (edge_cnt <= m_res_edge + 1) @(negedge clk);
    if (m_phase != 1) press(4'b0001, 1, 2);
    e = edge_cnt + 3;
    press(4'b0010, 1, 0);
    while (edge_cnt < e + 2) @(negedge clk);
    @(posedge clk);
    #2;
    if (q.size() > 0) void'(q.pop_back());
    m_phase = 0;
    m_win = 0;
    m_lose = 0;
    push(0, 0, 0, 0, 0, 0, -1);
    rst = 1'b0;
    #1 check("async_reset", 32'(snap_now()), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rel = edge_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_after_reset", 32'(state), 32'd0);
    end
    press(4'b0010, 1, 3);                    // hand in IDLE is ignored
    press(4'b0001, 1, 3);
    press_for_com(4'b1000, 2, N + 3);        // scissors vs paper: win

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
